// File: rtl/perm_input_deserializer_if.sv
// rtl/perm_input_deserializer_if.sv - coefficient stream in / packed frame out bundle
interface perm_input_deserializer_if #(
    parameter int SIZE  = 257,
    parameter int WIDTH = 32
);
    // Coefficient stream, one word per accepted cycle
    logic [WIDTH-1:0]      in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_last;
    logic [1:0]            in_perm;

    // Packed frame towards the permutation stage
    logic [SIZE*WIDTH-1:0] out_list;
    logic [1:0]            out_perm;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_short;

    // Producer of coefficients and consumer of frames (the surrounding datapath)
    modport master (
        output in_data, in_valid, in_last, in_perm, out_ready,
        input  in_ready, out_list, out_perm, out_valid, out_short
    );

    // The deserializer itself
    modport slave (
        input  in_data, in_valid, in_last, in_perm, out_ready,
        output in_ready, out_list, out_perm, out_valid, out_short
    );
endinterface

// File: rtl/perm_input_deserializer.sv
// rtl/perm_input_deserializer.sv - packs a coefficient stream into one flat frame for the permutation
module perm_input_deserializer #(
    parameter int SIZE  = 257,
    parameter int WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    perm_input_deserializer_if.slave  bus
);

    localparam int CNT_W = $clog2(SIZE + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SIZE - 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [SIZE*WIDTH-1:0] buffer;
    logic [1:0]            perm_q;
    logic                  short_q;
    logic                  in_ready_q;
    logic                  out_valid_q;

    logic                  accept;
    logic                  closing;

    // Handshake flags are registered copies of the state, so accept only needs in_valid
    assign accept  = bus.in_valid & in_ready_q;
    // Frame ends on the last slot or on an early in_last, whichever comes first
    assign closing = accept & ((cnt == LAST_IDX) | bus.in_last);

    // Frame collection FSM: FILL writes words into the buffer, FULL holds the frame until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            cnt         <= '0;
            buffer      <= '0;
            perm_q      <= 2'b00;
            short_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        // Constant-index decode keeps the write free of wide dynamic selects
                        for (int i = 0; i < SIZE; i++) begin
                            if (cnt == CNT_W'(i)) begin
                                buffer[i*WIDTH +: WIDTH] <= bus.in_data;
                            end
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == '0) begin
                            perm_q <= bus.in_perm;
                        end
                    end
                    if (closing) begin
                        state       <= FULL;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        // in_last on the final slot is an ordinary full frame
                        short_q     <= bus.in_last & (cnt != LAST_IDX);
                    end
                end
                FULL: begin
                    // Output handshake: clear everything together so the next frame starts from zeros
                    if (bus.out_ready) begin
                        state       <= FILL;
                        cnt         <= '0;
                        buffer      <= '0;
                        short_q     <= 1'b0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= FILL;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_list  = buffer;
    assign bus.out_perm  = perm_q;
    assign bus.out_short = short_q;

endmodule

// File: tb/tb_perm_input_deserializer.sv
// tb/tb_perm_input_deserializer.sv - scoreboard bench for perm_input_deserializer
module tb_perm_input_deserializer;

    localparam int SIZE  = 257;
    localparam int WIDTH = 32;
    localparam int LW    = SIZE * WIDTH;

    typedef struct {
        logic [LW-1:0] list;
        logic [1:0]    perm;
        logic          short_f;
    } frame_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    perm_input_deserializer_if #(.SIZE(SIZE), .WIDTH(WIDTH)) bus ();

    perm_input_deserializer #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    frame_t        sb[$];
    logic [LW-1:0] m_list;
    logic [1:0]    m_perm;
    int            m_cnt;
    int            last_acc_cyc;
    int            last_hs_cyc;
    logic          tog;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s actual=%h required=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_list(input string tag, input logic [LW-1:0] exp);
        int idx;
        idx = 0;
        n_checks++;
        assert (bus.out_list === exp) else begin
            for (int i = SIZE - 1; i >= 0; i--) begin
                if (bus.out_list[i*WIDTH +: WIDTH] !== exp[i*WIDTH +: WIDTH]) idx = i;
            end
            n_fail++;
            $error("FAIL %s word=%0d actual=%h required=%h", tag, idx,
                   bus.out_list[idx*WIDTH +: WIDTH], exp[idx*WIDTH +: WIDTH]);
        end
    endtask

    task automatic model_clear();
        m_list = '0;
        m_perm = 2'b00;
        m_cnt  = 0;
    endtask

    // Drive one word, wait for acceptance, record it in the model and check output timing
    task automatic send_word(input logic [WIDTH-1:0] d, input logic l, input logic [1:0] p);
        int     n;
        frame_t f;
        n = 0;
        bus.in_data  = d;
        bus.in_last  = l;
        bus.in_perm  = p;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 100) begin
            step();
            n++;
        end
        chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
        step();
        last_acc_cyc = cyc;
        bus.in_valid = 1'b0;
        if (m_cnt == 0) m_perm = p;
        m_list[m_cnt*WIDTH +: WIDTH] = d;
        m_cnt++;
        if (l || m_cnt == SIZE) begin
            f.list    = m_list;
            f.perm    = m_perm;
            f.short_f = l && (m_cnt < SIZE);
            sb.push_back(f);
            model_clear();
            chk("latency_out_valid", 32'(bus.out_valid), 32'd1);
            chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        end else begin
            chk("early_out_valid", 32'(bus.out_valid), 32'd0);
        end
    endtask

    task automatic check_front(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            chk_list({tag, "_list"}, sb[0].list);
            chk({tag, "_perm"}, 32'(bus.out_perm), 32'(sb[0].perm));
            chk({tag, "_short"}, 32'(bus.out_short), 32'(sb[0].short_f));
        end
    endtask

    // Wait for a frame, optionally stall the consumer while driving ignored input, then take it
    task automatic take_frame(input string tag, input int hold, input bit garbage);
        int n;
        n = 0;
        while (!bus.out_valid && n < 1000) begin
            step();
            n++;
        end
        if (hold > 0) begin
            bus.out_ready = 1'b0;
            for (int k = 0; k < hold; k++) begin
                if (garbage) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = $urandom;
                    bus.in_last  = 1'($urandom);
                end
                check_front({tag, "_hold"});
                chk({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
                step();
            end
            bus.in_valid = 1'b0;
        end
        check_front(tag);
        bus.out_ready = 1'b1;
        step();
        last_hs_cyc = cyc;
        if (sb.size() != 0) void'(sb.pop_front());
        chk({tag, "_after_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_after_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_after_short"}, 32'(bus.out_short), 32'd0);
        chk_list({tag, "_after_cleared"}, '0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_out_perm"}, 32'(bus.out_perm), 32'd0);
        chk({tag, "_out_short"}, 32'(bus.out_short), 32'd0);
        chk_list({tag, "_out_list"}, '0);
    endtask

    initial begin
        int first_acc;
        rst           = 1'b1;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_perm   = 2'b00;
        bus.out_ready = 1'b0;
        tog           = 1'b0;
        model_clear();
        step();
        step();
        rst = 1'b0;
        check_reset_state("reset");

        // Full frame, then stalled consumer with ignored input
        for (int i = 0; i < SIZE; i++)
            send_word(WIDTH'(i + 1), i == SIZE - 1, (i == 0) ? 2'b10 : 2'b01);
        take_frame("s1_s2", 10, 1'b1);

        // Short frames: five words, a single word, and SIZE-1 words
        for (int i = 0; i < 5; i++)
            send_word(WIDTH'(32'hA + i), i == 4, 2'b11);
        take_frame("s3_five", 0, 1'b0);
        send_word(32'hDEAD_BEEF, 1'b1, 2'b01);
        take_frame("s3_one", 2, 1'b0);
        for (int i = 0; i < SIZE - 1; i++)
            send_word($urandom, i == SIZE - 2, 2'b00);
        take_frame("s3_size_m1", 0, 1'b0);

        // Random gaps, toggling select, frame closed by count alone
        for (int i = 0; i < SIZE; i++) begin
            int gaps;
            gaps = $urandom_range(0, 3);
            for (int g = 0; g < gaps; g++) begin
                bus.in_valid = 1'b0;
                bus.in_perm  = tog ? 2'b01 : 2'b10;
                tog = ~tog;
                step();
            end
            send_word(WIDTH'(i + 1), 1'b0, tog ? 2'b01 : 2'b10);
            tog = ~tog;
        end
        take_frame("s4_gaps", 3, 1'b0);

        // Reset mid-frame, then a fresh frame
        for (int i = 0; i < 100; i++)
            send_word(32'h5500_0000 + 32'(i), 1'b0, 2'b11);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_clear();
        check_reset_state("s5_reset");
        for (int i = 0; i < SIZE; i++)
            send_word(32'h0100_0000 + 32'(i * 3), i == SIZE - 1, 2'b01);
        take_frame("s5_fresh", 0, 1'b0);

        // Two frames back-to-back with the consumer always ready
        bus.out_ready = 1'b1;
        for (int i = 0; i < SIZE; i++)
            send_word(32'hA000_0000 + 32'(i), 1'b0, 2'b10);
        take_frame("s6_a", 0, 1'b0);
        send_word(32'hB000_0000, 1'b0, 2'b11);
        first_acc = last_acc_cyc;
        chk("s6_first_accept_gap", 32'(first_acc - last_hs_cyc), 32'd1);
        for (int i = 1; i < 40; i++)
            send_word(32'hB000_0000 + 32'(i), i == 39, 2'b00);
        take_frame("s6_b", 0, 1'b0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
